// File: rtl/elm_output_sequencer_if.sv
// Bus bundle between the ELM output sequencer and its surroundings: MAC datapath,
// hidden/weight memories, downstream argmax block and the result consumer.
// master = sequencer side, slave = environment side.
interface elm_output_sequencer_if #(
    parameter int unsigned ACC_WIDTH = 21,
    parameter int unsigned H_ADDR_W  = 6,
    parameter int unsigned W_ADDR_W  = 10
);
    logic                    start;
    logic                    busy;
    logic [H_ADDR_W-1:0]     hid_addr;
    logic [W_ADDR_W-1:0]     w_addr;
    logic                    mac_en;
    logic                    mac_clear;
    logic [ACC_WIDTH-1:0]    mac_result;
    logic [10*ACC_WIDTH-1:0] scores;
    logic                    argmax_load;
    logic                    argmax_update;
    logic [3:0]              argmax_index;
    logic [3:0]              result_index;
    logic                    result_valid;
    logic                    result_ready;

    modport master (
        input  start, mac_result, argmax_update, argmax_index, result_ready,
        output busy, hid_addr, w_addr, mac_en, mac_clear, scores, argmax_load,
               result_index, result_valid
    );

    modport slave (
        output start, mac_result, argmax_update, argmax_index, result_ready,
        input  busy, hid_addr, w_addr, mac_en, mac_clear, scores, argmax_load,
               result_index, result_valid
    );
endinterface

// File: rtl/elm_output_sequencer.sv
// ELM output-layer sequencer. For one inference it streams 10 classes x NUM_HIDDEN
// hidden activations through a shared clear-and-accumulate MAC, banks the 10 class
// scores, hands them to the argmax block and returns the winning class over a
// valid/ready handshake.
// Optional build macro: ELM_SEQ_TIMEOUT_EN bounds the argmax wait to TIMEOUT cycles
// and reports 4'hF on expiry; without it the wait is unbounded and no counter exists.
module elm_output_sequencer #(
    parameter int unsigned NUM_HIDDEN  = 64,
    parameter int unsigned ACC_WIDTH   = 21,
    parameter int unsigned H_ADDR_W    = 6,
    parameter int unsigned W_ADDR_W    = 10,
    parameter int unsigned MAC_LATENCY = 2,
    parameter int unsigned TIMEOUT     = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    elm_output_sequencer_if.master io_bus
);
    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned D_W         = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    if (NUM_HIDDEN < 1 || MAC_LATENCY < 1 || TIMEOUT < 1) begin : g_bad_count
        $error("elm_output_sequencer: NUM_HIDDEN, MAC_LATENCY and TIMEOUT must be >= 1");
    end
    if ((1 << H_ADDR_W) < NUM_HIDDEN || (1 << W_ADDR_W) < NUM_CLASSES * NUM_HIDDEN)
    begin : g_bad_addr_w
        $error("elm_output_sequencer: address widths too small for NUM_HIDDEN");
    end

    typedef enum logic [2:0] {
        StIdle,
        StMac,
        StDrain,
        StLoad,
        StWait,
        StResult
    } state_t;

    state_t                           r_state;
    state_t                           w_state_next;
    logic [H_ADDR_W-1:0]              r_j;
    logic [3:0]                       r_k;
    logic [W_ADDR_W-1:0]              r_w_addr;
    logic [D_W-1:0]                   r_d;
    logic [NUM_CLASSES*ACC_WIDTH-1:0] r_scores;
    logic [3:0]                       r_result_index;
    logic                             w_last_j;
    logic                             w_last_d;
    logic                             w_last_k;
    logic                             w_wait_timeout;

    assign w_last_j = (r_j == H_ADDR_W'(NUM_HIDDEN - 1));
    assign w_last_d = (r_d == D_W'(MAC_LATENCY - 1));
    assign w_last_k = (r_k == 4'(NUM_CLASSES - 1));

`ifdef ELM_SEQ_TIMEOUT_EN
    localparam int unsigned T_W = $clog2(TIMEOUT + 1);

    logic [T_W-1:0] r_wait_cnt;

    assign w_wait_timeout = (r_wait_cnt == T_W'(TIMEOUT - 1));

    // WAIT-cycle counter; held at zero outside WAIT so each inference starts fresh.
    always_ff @(posedge clock) begin
        if (reset || r_state != StWait) begin
            r_wait_cnt <= '0;
        end else begin
            r_wait_cnt <= r_wait_cnt + T_W'(1);
        end
    end
`else
    assign w_wait_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and state-decoded (Moore) control outputs.
    always_comb begin
        w_state_next        = r_state;
        io_bus.busy         = 1'b1;
        io_bus.mac_en       = 1'b0;
        io_bus.mac_clear    = 1'b0;
        io_bus.argmax_load  = 1'b0;
        io_bus.result_valid = 1'b0;
        unique case (r_state)
            StIdle: begin
                io_bus.busy = 1'b0;
                if (io_bus.start) begin
                    w_state_next = StMac;
                end
            end
            StMac: begin
                io_bus.mac_en    = 1'b1;
                io_bus.mac_clear = (r_j == '0);
                if (w_last_j) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                if (w_last_d) begin
                    w_state_next = w_last_k ? StLoad : StMac;
                end
            end
            StLoad: begin
                io_bus.argmax_load = 1'b1;
                w_state_next       = StWait;
            end
            StWait: begin
                if (io_bus.argmax_update || w_wait_timeout) begin
                    w_state_next = StResult;
                end
            end
            StResult: begin
                io_bus.result_valid = 1'b1;
                if (io_bus.result_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Address counters, score bank and result capture. The weight address runs as one
    // linear counter across classes, which equals k*NUM_HIDDEN + j on every MAC cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_j            <= '0;
            r_k            <= '0;
            r_w_addr       <= '0;
            r_d            <= '0;
            r_scores       <= '0;
            r_result_index <= '0;
        end else begin
            unique case (r_state)
                StMac: begin
                    r_w_addr <= r_w_addr + W_ADDR_W'(1);
                    if (w_last_j) begin
                        r_j <= '0;
                    end else begin
                        r_j <= r_j + H_ADDR_W'(1);
                    end
                end
                StDrain: begin
                    if (w_last_d) begin
                        r_scores[r_k * ACC_WIDTH +: ACC_WIDTH] <= io_bus.mac_result;
                        r_d <= '0;
                        r_k <= r_k + 4'd1;
                    end else begin
                        r_d <= r_d + D_W'(1);
                    end
                end
                StLoad: begin
                    // Rewind so IDLE presents zero addresses and the next run starts at k=0.
                    r_k      <= '0;
                    r_w_addr <= '0;
                end
                StWait: begin
                    if (io_bus.argmax_update) begin
                        r_result_index <= io_bus.argmax_index;
                    end else if (w_wait_timeout) begin
                        r_result_index <= 4'hF;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign io_bus.hid_addr     = r_j;
    assign io_bus.w_addr       = r_w_addr;
    assign io_bus.scores       = r_scores;
    assign io_bus.result_index = r_result_index;

endmodule

// File: tb/tb_elm_output_sequencer.sv
// Directed bench for elm_output_sequencer with NUM_HIDDEN=4, MAC_LATENCY=2.
// An environment process models the weight/hidden memories, the MAC (latency 2)
// and the argmax block; each test task checks its own expectations inline.
module tb_elm_output_sequencer;
    localparam int unsigned NH = 4;
    localparam int unsigned AW = 21;
    localparam int unsigned HW = 2;
    localparam int unsigned WW = 6;
    localparam int unsigned ML = 2;
    localparam int unsigned TO = 32;

    logic clock = 1'b0;
    logic reset;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   w_mem [64];
    int   h_mem [4];
    int   exp_score [10];
    int   arg_delay = 1;
    int   arg_pend  = 0;
    int   arg_best  = 0;

    elm_output_sequencer_if #(.ACC_WIDTH(AW), .H_ADDR_W(HW), .W_ADDR_W(WW)) bus_if ();

    elm_output_sequencer #(
        .NUM_HIDDEN (NH),
        .ACC_WIDTH  (AW),
        .H_ADDR_W   (HW),
        .W_ADDR_W   (WW),
        .MAC_LATENCY(ML),
        .TIMEOUT    (TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io_bus(bus_if)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Environment: memories + MAC sampled mid-cycle, applied 1 time unit after the edge.
    initial begin : env
        int en_s;
        int clr_s;
        int prod_s;
        int acc;
        int best_v;
        int v;
        logic signed [AW-1:0] sv;
        acc = 0;
        bus_if.mac_result    = '0;
        bus_if.argmax_update = 1'b0;
        bus_if.argmax_index  = 4'd0;
        forever begin
            @(negedge clock);
            en_s   = int'(bus_if.mac_en);
            clr_s  = int'(bus_if.mac_clear);
            prod_s = w_mem[bus_if.w_addr] * h_mem[bus_if.hid_addr];
            if (bus_if.argmax_load === 1'b1 && arg_delay > 0) begin
                sv       = bus_if.scores[0 +: AW];
                best_v   = int'(sv);
                arg_best = 0;
                for (int k = 1; k < 10; k++) begin
                    sv = bus_if.scores[k*AW +: AW];
                    v  = int'(sv);
                    if (v > best_v) begin
                        best_v   = v;
                        arg_best = k;
                    end
                end
                arg_pend = arg_delay;
            end
            @(posedge clock);
            #1;
            bus_if.mac_result = AW'(acc);
            if (en_s != 0) acc = (clr_s != 0) ? prod_s : acc + prod_s;
            bus_if.argmax_update = 1'b0;
            if (arg_pend > 0) begin
                arg_pend = arg_pend - 1;
                if (arg_pend == 0) begin
                    bus_if.argmax_update = 1'b1;
                    bus_if.argmax_index  = 4'(arg_best);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    // mode 0: class k weights all k except class 7 = 12, hidden 1..4 -> score 10k, class 7 = 120.
    // mode 1: hidden all 1, class 0 sums to -1, every other class to -5.
    task automatic set_tables(input int mode);
        for (int a = 0; a < 64; a++) w_mem[a] = 0;
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < int'(NH); j++) begin
                if (mode == 0) begin
                    h_mem[j]       = j + 1;
                    w_mem[k*4 + j] = (k == 7) ? 12 : k;
                end else begin
                    h_mem[j]       = 1;
                    w_mem[k*4 + j] = (k == 0) ? ((j == 0) ? 1 : (j == 3) ? 0 : -1)
                                              : ((j == 0) ? -2 : -1);
                end
            end
        end
        for (int k = 0; k < 10; k++) begin
            exp_score[k] = 0;
            for (int j = 0; j < int'(NH); j++) exp_score[k] += w_mem[k*4 + j] * h_mem[j];
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_if.start = 1'b1;
        bus_if.result_ready = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        vectors++;
        if ({bus_if.busy, bus_if.mac_en, bus_if.mac_clear, bus_if.argmax_load,
             bus_if.result_valid} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, expected 00000", {bus_if.busy, bus_if.mac_en,
                     bus_if.mac_clear, bus_if.argmax_load, bus_if.result_valid});
        end
        vectors++;
        if ({bus_if.hid_addr, bus_if.w_addr, bus_if.result_index} !== '0) begin
            miscompares++;
            $display("FAIL reset_addr: got hid %0h w %0h idx %0h, expected 0",
                     bus_if.hid_addr, bus_if.w_addr, bus_if.result_index);
        end
        vectors++;
        if (bus_if.scores !== '0) begin
            miscompares++;
            $display("FAIL reset_scores: got %0h, expected 0", bus_if.scores);
        end
        reset = 1'b0;
        bus_if.start = 1'b0;
        @(negedge clock);
        vectors++;
        if (bus_if.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_start_ignored: busy got %b, expected 0", bus_if.busy);
        end
    endtask

    task automatic test_nominal();
        int t0, rel, k, ph, seq_err, load_rel, load_cnt, valid_rel;
        int w7 [4];
        logic [AW-1:0] got;
        set_tables(0);
        arg_delay = 1;
        bus_if.result_ready = 1'b1;
        for (int i = 0; i < 4; i++) w7[i] = -1;
        seq_err = 0; load_rel = -1; load_cnt = 0; valid_rel = -1;
        @(negedge clock);
        bus_if.start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 200 && valid_rel < 0; i++) begin
            @(negedge clock);
            bus_if.start = 1'b0;
            rel = cyc - t0 + 1;
            if (rel >= 2 && rel <= 61) begin
                k  = (rel - 2) / 6;
                ph = (rel - 2) % 6;
                if (ph < 4) begin
                    if (bus_if.mac_en !== 1'b1 || bus_if.hid_addr !== HW'(ph) ||
                        bus_if.w_addr !== WW'(k*4 + ph) || bus_if.mac_clear !== (ph == 0))
                        seq_err++;
                    if (k == 7) w7[ph] = int'(bus_if.w_addr);
                end else if (bus_if.mac_en !== 1'b0 || bus_if.mac_clear !== 1'b0) begin
                    seq_err++;
                end
                if (bus_if.busy !== 1'b1 || bus_if.argmax_load !== 1'b0) seq_err++;
            end
            if (bus_if.argmax_load === 1'b1) begin
                load_cnt++;
                if (load_rel < 0) load_rel = rel;
            end
            if (bus_if.result_valid === 1'b1) valid_rel = rel;
        end
        vectors++;
        if (seq_err != 0) begin
            miscompares++;
            $display("FAIL nom_mac_sequence: got %0d bad cycles, expected 0", seq_err);
        end
        for (int j = 0; j < 4; j++) begin
            vectors++;
            if (w7[j] != 28 + j) begin
                miscompares++;
                $display("FAIL nom_w_addr_k7_j%0d: got %0d, expected %0d", j, w7[j], 28 + j);
            end
        end
        vectors++;
        if (load_rel != 62 || load_cnt != 1) begin
            miscompares++;
            $display("FAIL nom_argmax_load: got cycle %0d count %0d, expected cycle 62 count 1",
                     load_rel, load_cnt);
        end
        vectors++;
        if (valid_rel != 64) begin
            miscompares++;
            $display("FAIL nom_valid_cycle: got %0d, expected 64", valid_rel);
        end
        vectors++;
        if (bus_if.result_index !== 4'd7) begin
            miscompares++;
            $display("FAIL nom_result_index: got %0d, expected 7", bus_if.result_index);
        end
        for (int c = 0; c < 10; c++) begin
            got = bus_if.scores[c*AW +: AW];
            vectors++;
            if (got !== AW'(exp_score[c])) begin
                miscompares++;
                $display("FAIL nom_score%0d: got %0d, expected %0d", c, $signed(got),
                         exp_score[c]);
            end
        end
        @(negedge clock);
        vectors++;
        if (bus_if.result_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL nom_after_handshake: got valid %b busy %b, expected 0 0",
                     bus_if.result_valid, bus_if.busy);
        end
        bus_if.result_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int t0, rel, valid_rel, hold_err;
        set_tables(0);
        arg_delay = 1;
        bus_if.result_ready = 1'b0;
        valid_rel = -1;
        @(negedge clock);
        bus_if.start = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 200 && valid_rel < 0; i++) begin
            @(negedge clock);
            rel = cyc - t0 + 1;
            bus_if.start = (rel == 10);
            if (bus_if.result_valid === 1'b1) valid_rel = rel;
        end
        bus_if.start = 1'b0;
        vectors++;
        if (valid_rel != 64) begin
            miscompares++;
            $display("FAIL bp_valid_cycle: got %0d, expected 64", valid_rel);
        end
        hold_err = 0;
        for (int i = 0; i < 5; i++) begin
            bus_if.start = (i == 2);
            @(negedge clock);
            if (bus_if.result_valid !== 1'b1 || bus_if.result_index !== 4'd7 ||
                bus_if.busy !== 1'b1) hold_err++;
        end
        vectors++;
        if (hold_err != 0) begin
            miscompares++;
            $display("FAIL bp_hold: got %0d bad cycles, expected 0", hold_err);
        end
        bus_if.result_ready = 1'b1;
        bus_if.start = 1'b1;
        @(negedge clock);
        vectors++;
        if (bus_if.result_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_release: got valid %b busy %b, expected 0 0",
                     bus_if.result_valid, bus_if.busy);
        end
        bus_if.start = 1'b0;
        bus_if.result_ready = 1'b0;
        @(negedge clock);
        vectors++;
        if (bus_if.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_handshake_start_ignored: busy got %b, expected 0", bus_if.busy);
        end
    endtask

    task automatic test_reset_mid();
        int err;
        set_tables(0);
        arg_delay = 1;
        bus_if.result_ready = 1'b1;
        @(negedge clock);
        bus_if.start = 1'b1;
        @(negedge clock);
        bus_if.start = 1'b0;
        repeat (20) @(negedge clock);
        vectors++;
        if (bus_if.mac_en !== 1'b1 || bus_if.hid_addr !== HW'(2) || bus_if.w_addr !== WW'(14)) begin
            miscompares++;
            $display("FAIL mid_position: got en %b hid %0d w %0d, expected 1 2 14",
                     bus_if.mac_en, bus_if.hid_addr, bus_if.w_addr);
        end
        reset = 1'b1;
        @(negedge clock);
        vectors++;
        if (bus_if.busy !== 1'b0 || bus_if.mac_en !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_abort: got busy %b mac_en %b, expected 0 0",
                     bus_if.busy, bus_if.mac_en);
        end
        reset = 1'b0;
        err = 0;
        repeat (80) begin
            @(negedge clock);
            if (bus_if.argmax_load !== 1'b0 || bus_if.result_valid !== 1'b0 ||
                bus_if.busy !== 1'b0) err++;
        end
        vectors++;
        if (err != 0) begin
            miscompares++;
            $display("FAIL mid_no_result: got %0d active cycles, expected 0", err);
        end
        bus_if.result_ready = 1'b0;
    endtask

    task automatic test_negative();
        int valid_seen;
        logic [AW-1:0] got;
        set_tables(1);
        arg_delay = 1;
        bus_if.result_ready = 1'b1;
        valid_seen = 0;
        @(negedge clock);
        bus_if.start = 1'b1;
        for (int i = 0; i < 200 && valid_seen == 0; i++) begin
            @(negedge clock);
            bus_if.start = 1'b0;
            if (bus_if.result_valid === 1'b1) valid_seen = 1;
        end
        vectors++;
        if (valid_seen != 1 || bus_if.result_index !== 4'd0) begin
            miscompares++;
            $display("FAIL neg_result_index: got valid %0d idx %0d, expected 1 0",
                     valid_seen, bus_if.result_index);
        end
        for (int c = 0; c < 10; c++) begin
            got = bus_if.scores[c*AW +: AW];
            vectors++;
            if (got !== AW'(exp_score[c])) begin
                miscompares++;
                $display("FAIL neg_score%0d: got %0d, expected %0d", c, $signed(got),
                         exp_score[c]);
            end
        end
        @(negedge clock);
        bus_if.result_ready = 1'b0;
    endtask

    task automatic test_timeout();
        int t0, rel, load_rel, valid_rel, err;
        set_tables(0);
        arg_delay = 0;
        bus_if.result_ready = 1'b0;
        load_rel = -1; valid_rel = -1; err = 0;
        @(negedge clock);
        bus_if.start = 1'b1;
        t0 = cyc;
`ifdef ELM_SEQ_TIMEOUT_EN
        for (int i = 0; i < 200 && valid_rel < 0; i++) begin
            @(negedge clock);
            bus_if.start = 1'b0;
            rel = cyc - t0 + 1;
            if (bus_if.argmax_load === 1'b1 && load_rel < 0) load_rel = rel;
            if (bus_if.result_valid === 1'b1) valid_rel = rel;
        end
        vectors++;
        if (load_rel != 62 || valid_rel != 95) begin
            miscompares++;
            $display("FAIL to_cycle: got load %0d valid %0d, expected 62 95", load_rel, valid_rel);
        end
        vectors++;
        if (bus_if.result_index !== 4'hF) begin
            miscompares++;
            $display("FAIL to_index: got %0h, expected f", bus_if.result_index);
        end
        arg_best = 3;
        arg_pend = 1;
        repeat (2) @(negedge clock);
        vectors++;
        if (bus_if.result_valid !== 1'b1 || bus_if.result_index !== 4'hF) begin
            miscompares++;
            $display("FAIL to_late_update: got valid %b idx %0h, expected 1 f",
                     bus_if.result_valid, bus_if.result_index);
        end
        bus_if.result_ready = 1'b1;
        @(negedge clock);
        vectors++;
        if (bus_if.result_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL to_release: got valid %b busy %b, expected 0 0",
                     bus_if.result_valid, bus_if.busy);
        end
        bus_if.result_ready = 1'b0;
`else
        for (int i = 0; i < 102; i++) begin
            @(negedge clock);
            bus_if.start = 1'b0;
            rel = cyc - t0 + 1;
            if (bus_if.argmax_load === 1'b1 && load_rel < 0) load_rel = rel;
            if (bus_if.busy !== 1'b1 || bus_if.result_valid !== 1'b0) err++;
        end
        vectors++;
        if (load_rel != 62) begin
            miscompares++;
            $display("FAIL wait_load_cycle: got %0d, expected 62", load_rel);
        end
        vectors++;
        if (err != 0) begin
            miscompares++;
            $display("FAIL wait_blocks: got %0d cycles not busy or valid, expected 0", err);
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        vectors++;
        if (bus_if.busy !== 1'b0 || bus_if.result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_recover: got busy %b valid %b, expected 0 0",
                     bus_if.busy, bus_if.result_valid);
        end
`endif
        arg_delay = 1;
    endtask

    initial begin
        reset               = 1'b1;
        bus_if.start        = 1'b0;
        bus_if.result_ready = 1'b0;
        set_tables(0);
        test_reset();
        test_nominal();
        test_backpressure();
        test_reset_mid();
        test_negative();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
